// File: rtl/regfile_pkg.sv
// Shared defaults, requester indices and the saturating-counter helper for the
// register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned REG_WIDTH_DEF      = 8;
  localparam int unsigned REG_FILE_DEPTH_DEF = 8;
  localparam int unsigned REG_DIR_WIDTH_DEF  = 3;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam logic [7:0] CONFLICT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == CONFLICT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_ptr names the requester preferred on the next
// contended cycle and flips only when both requesters are valid and granted.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (!hold) begin
      if (&valid) begin
        grant    = (rr_ptr_q == REQ_ALU) ? 2'b01 : 2'b10;
        rr_ptr_d = ~rr_ptr_q;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= REQ_ALU;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU (req0) and load (req1) writeback.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write onto the read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned REG_WIDTH      = REG_WIDTH_DEF,
  parameter int unsigned REG_FILE_DEPTH = REG_FILE_DEPTH_DEF,
  parameter int unsigned REG_DIR_WIDTH  = $clog2(REG_FILE_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     req0_valid,
  input  logic [REG_DIR_WIDTH-1:0] req0_dir,
  input  logic [REG_WIDTH-1:0]     req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [REG_DIR_WIDTH-1:0] req1_dir,
  input  logic [REG_WIDTH-1:0]     req1_data,
  output logic                     req1_ready,
  output logic                     RegWrite,
  output logic [REG_DIR_WIDTH-1:0] writer,
  output logic [REG_WIDTH-1:0]     writedata,
  input  logic [REG_DIR_WIDTH-1:0] readr1,
  input  logic [REG_DIR_WIDTH-1:0] readr2,
  input  logic [REG_WIDTH-1:0]     rf_readd1,
  input  logic [REG_WIDTH-1:0]     rf_readd2,
  output logic [REG_WIDTH-1:0]     readd1,
  output logic [REG_WIDTH-1:0]     readd2,
  output logic [7:0]               conflicts
);

  logic [1:0]               valid, grant;
  logic [REG_DIR_WIDTH-1:0] sel_dir;
  logic [REG_WIDTH-1:0]     sel_data;
  logic                     wr_en_d;

  logic                     reg_write_q;
  logic [REG_DIR_WIDTH-1:0] writer_q;
  logic [REG_WIDTH-1:0]     writedata_q;
  logic [7:0]               conflicts_q;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .valid (valid),
    .grant (grant)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_MEM];

  always_comb begin
    sel_dir  = req0_dir;
    sel_data = req0_data;
    if (grant[REQ_MEM]) begin
      sel_dir  = req1_dir;
      sel_data = req1_data;
    end
    // r0 is hardwired zero: the handshake completes but nothing is written.
    wr_en_d = (|grant) && (sel_dir != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      writer_q    <= '0;
      writedata_q <= '0;
      conflicts_q <= '0;
    end else begin
      reg_write_q <= wr_en_d;
      if (wr_en_d) begin
        writer_q    <= sel_dir;
        writedata_q <= sel_data;
      end
      if ((&valid) && !hold) begin
        conflicts_q <= sat_inc(conflicts_q);
      end
    end
  end

  assign RegWrite  = reg_write_q;
  assign writer    = writer_q;
  assign writedata = writedata_q;
  assign conflicts = conflicts_q;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    readd1 = rf_readd1;
    readd2 = rf_readd2;
    if (reg_write_q && (readr1 == writer_q) && (readr1 != '0)) readd1 = writedata_q;
    if (reg_write_q && (readr2 == writer_q) && (readr2 != '0)) readd2 = writedata_q;
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{readr1, readr2};
  assign readd1 = rf_readd1;
  assign readd2 = rf_readd2;
`endif

endmodule
